// File: rtl/rx_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | rx_ctrl_pkg : shared types and constants for the rx command scheduler |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] RSP_OK     = 8'hAC;
  localparam logic [7:0] RSP_BADMOD = 8'hE1;
  localparam logic [7:0] RSP_TMO    = 8'hE2;

  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0] mod;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/rx_ctrl_fifo.sv
// +----------------------------------------------------------------------+
// | rx_ctrl_fifo : 4-deep synchronous FIFO, push while full is allowed   |
// | when a pop happens in the same cycle.  Rev 1.0                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rx_ctrl_fifo
  import rx_ctrl_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int              c_aw   = $clog2(FIFO_DEPTH);
  localparam logic [c_aw-1:0] c_one  = 1;
  localparam logic [c_aw:0]   c_full = (c_aw + 1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_inc  = 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_rd_en;
  logic             w_wr_en;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_full);
  assign pop_data = r_mem[r_rd_ptr];
  assign w_rd_en  = pop & ~empty;
  // Fullness is judged after the same-cycle pop frees a slot.
  assign w_wr_en  = push & (~full | w_rd_en);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_one;
      end
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_one;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_inc;
        2'b01:   r_count <= r_count - c_inc;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_ctrl_sched.sv
// +----------------------------------------------------------------------+
// | rx_ctrl_sched : filters decoded commands, queues them and dispatches |
// | one at a time to module ports, returning a status byte each. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module rx_ctrl_sched
  import rx_ctrl_pkg::*;
#(
  parameter logic [7:0]  DEV_ID  = 8'h01,
  parameter int          NUM_MOD = 4,
  parameter logic [15:0] ACK_TMO = 16'd50000
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [7:0]         cmdr_dev,
  input  logic [7:0]         cmdr_mod,
  input  logic [7:0]         cmdr_addr,
  input  logic [7:0]         cmdr_data,
  input  logic               cmdr_vld,
  output logic [NUM_MOD-1:0] mod_req,
  output logic [7:0]         mod_addr,
  output logic [7:0]         mod_data,
  input  logic [NUM_MOD-1:0] mod_ack,
  output logic               rsp_vld,
  output logic [7:0]         rsp_code,
  input  logic               rsp_rdy,
  output logic [7:0]         stat_drop
);

  localparam logic [15:0] c_tmo_last = ACK_TMO - 16'd1;
  localparam logic [7:0]  c_num_mod  = 8'(NUM_MOD);

  state_t             r_state;
  cmd_t               r_cur;
  logic [15:0]        r_tmo_cnt;
  cmd_t               w_cmd_in;
  cmd_t               w_head;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_mod_ok;
  logic               w_ack;
  logic [NUM_MOD-1:0] w_sel;

  assign w_cmd_in = {cmdr_mod, cmdr_addr, cmdr_data};
  assign w_push   = cmdr_vld & (cmdr_dev == DEV_ID);
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  assign w_mod_ok = (r_cur.mod < c_num_mod);

  generate
    for (genvar i = 0; i < NUM_MOD; i++) begin : g_sel
      assign w_sel[i] = (r_cur.mod == 8'(i));
    end
  endgenerate

  // Only the ack of the module being served counts.
  assign w_ack = |(mod_ack & w_sel);

  rx_ctrl_fifo #(
    .WIDTH($bits(cmd_t))
  ) u_fifo (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_cmd_in),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stat_drop <= '0;
    end else if (w_push && w_full && !w_pop && (stat_drop != 8'hFF)) begin
      stat_drop <= stat_drop + 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_tmo_cnt <= '0;
      mod_req   <= '0;
      mod_addr  <= '0;
      mod_data  <= '0;
      rsp_vld   <= 1'b0;
      rsp_code  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cur   <= w_head;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_mod_ok) begin
            mod_req   <= w_sel;
            mod_addr  <= r_cur.addr;
            mod_data  <= r_cur.data;
            r_tmo_cnt <= '0;
            r_state   <= S_WAIT;
          end else begin
            rsp_vld  <= 1'b1;
            rsp_code <= RSP_BADMOD;
            r_state  <= S_RESP;
          end
        end
        S_WAIT: begin
          // An ack on the last counted cycle beats the timeout.
          if (w_ack) begin
            mod_req  <= '0;
            rsp_vld  <= 1'b1;
            rsp_code <= RSP_OK;
            r_state  <= S_RESP;
          end else if (r_tmo_cnt == c_tmo_last) begin
            mod_req  <= '0;
            rsp_vld  <= 1'b1;
            rsp_code <= RSP_TMO;
            r_state  <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/rx_ctrl_sched.md
# rx_ctrl_sched

Command scheduler behind the receive-side command decoder. It accepts decoded 4-byte commands (dev/mod/addr/data plus a one-cycle valid), filters on device ID and queues them in a 4-entry FIFO. It dispatches each command to one of `NUM_MOD` module ports with a req/ack handshake and an ack timeout. It returns one status byte per dispatched command to the transmit path.

## Interface
Parameters:
- `DEV_ID`, 8'h01: device ID this board answers to.
- `NUM_MOD`, 4: number of module ports (1..8).
- `ACK_TMO`, 16'd50000: `clk_sys` cycles to wait for a module ack (must be ≥ 2).

Ports:
- `clk_sys`, in, 1: system clock; the block has one clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmdr_dev`, in, 8: decoded device byte.
- `cmdr_mod`, in, 8: decoded module index.
- `cmdr_addr`, in, 8: decoded register address.
- `cmdr_data`, in, 8: decoded data byte.
- `cmdr_vld`, in, 1: one-cycle pulse; the four bytes are stable in this cycle.
- `mod_req`, out, `NUM_MOD`: one-hot request level, held until ack or timeout.
- `mod_addr`, out, 8: address for the active request.
- `mod_data`, out, 8: data for the active request.
- `mod_ack`, in, `NUM_MOD`: per-module ack, 1-cycle or level.
- `rsp_vld`, out, 1: status byte valid, held until taken.
- `rsp_code`, out, 8: status byte.
- `rsp_rdy`, in, 1: transmit path accepts `rsp_code` when `rsp_vld & rsp_rdy`.
- `stat_drop`, out, 8: count of commands lost to a full FIFO, saturating.

## Operation
- **Input filter.** When `cmdr_vld` is high and `cmdr_dev != DEV_ID`, the command is ignored. It produces no response and no count.
- **FIFO.** 4 entries of {mod, addr, data}, 24 bits each. A push while full is discarded and `stat_drop` increments, saturating at 8'hFF.
- **Push/pop in the same cycle.** When the FIFO is full, a push and a pop in the same cycle both succeed; fullness is evaluated after the pop.
- **FSM states and transitions:**
  - IDLE → ISSUE when the FIFO is non-empty. The pop latches the entry into `cur_*`.
  - ISSUE → WAIT when `cur_mod < NUM_MOD`. `mod_req[cur_mod]` is set, and `mod_addr`/`mod_data` are driven from `cur_*`.
  - ISSUE → RESP when `cur_mod >= NUM_MOD`, with `rsp_code=8'hE1`. No request is issued.
  - WAIT → RESP on `mod_ack[cur_mod]`, with `rsp_code=8'hAC`.
  - WAIT → RESP on timeout, with `rsp_code=8'hE2`.
  - Leaving WAIT clears `mod_req`. Acks on other bits are ignored.
  - RESP: `rsp_vld` is high. On `rsp_vld & rsp_rdy`, clear `rsp_vld` → IDLE.
- **Timeout.** A 16-bit counter is cleared on entry to WAIT and increments each WAIT cycle. Timeout fires when the counter reaches `ACK_TMO-1` with no ack. An ack in that same cycle wins.
- **Queueing.** Commands keep arriving and queueing during WAIT and RESP. Order is strict FIFO, one command in flight.
- **Reset values.** All outputs are 0, the FIFO is empty and the FSM is in IDLE. Reset mid-operation drops queued and in-flight commands with no response. `stat_drop` clears only on reset.

## Timing
- `cmdr_vld` in cycle T: FIFO written at the end of T.
- IDLE pops in T+1; ISSUE in T+2; WAIT with `mod_req` high in T+3.
- Ack sampled in cycle W: `mod_req` is low and `rsp_vld` is high in W+1.
- Back-to-back commands: the next pop comes at the earliest 1 cycle after the response handshake (IDLE cycle).
- `rsp_code` is stable while `rsp_vld` is high. `mod_addr`/`mod_data` are stable while `mod_req` is high.
- All outputs are registered.

## Structure
- Shared package (`rx_ctrl_pkg`):
  - FSM state encoding: S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3.
  - Response codes: RSP_OK=8'hAC, RSP_BADMOD=8'hE1, RSP_TMO=8'hE2.
  - FIFO depth constant.
- One sub-module: `rx_ctrl_fifo`, a parametric-width, 4-deep synchronous FIFO with full/empty and simultaneous push/pop. The FSM, filter, timeout counter and drop counter stay in the top level.

## Test plan
- Single command dev=01, mod=2, addr=10, data=5A, module 2 acks 3 cycles after req:
  - `mod_req=4'b0100` in T+3; `mod_addr=10`, `mod_data=5A`.
  - `rsp_code=AC` one cycle after the ack.
- dev=03 command → nothing happens: no req, no rsp, `stat_drop=0`.
- mod=07 with `NUM_MOD=4` → no `mod_req`; `rsp_code=E1` in T+3.
- Module never acks, `ACK_TMO=16` → `mod_req` high exactly 16 cycles, then `rsp_code=E2`.
- 6 commands pushed while module 0 is stalled:
  - 1 is in flight and 4 are queued, so `stat_drop=1`.
  - After acks, exactly 5 responses come out, in order.
- Hold `rsp_rdy=0` for 10 cycles: `rsp_vld` and `rsp_code` are held. Then assert `rst_n=0` mid-WAIT of the next command: all outputs are 0 at once and no response follows.
